cpu_mem_responder: RTL and testbench
====================================

# cpu_mem_responder

Responder side of the CPU memory port: accepts word read/write requests from the multicycle control path, services them from an internal byte-organised big-endian store after a fixed number of wait states, and signals completion with a one-cycle `Ready` pulse so the control FSM can stall on slow memory. It replaces the fixed single-cycle memory behind the `IorD` address mux and the `StoreSize` write-data path.

## Interface
- `DEPTH_WORDS`, 64: storage depth in 32-bit words; power of two, at least 2.
- `WAIT_STATES`, 1: extra cycles between request acceptance and completion; range 0..15.
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `Req`  in  1: access request, sampled on the rising edge.
- `Wr`  in  1: 1 = write, 0 = read; sampled with `Req`.
- `Address`  in  32: byte address; sampled with `Req`.
- `DataIn`  in  32: write data; sampled with `Req`.
- `DataOut`  out  32: read data; registered.
- `Ready`  out  1: one-cycle completion pulse.
- `Fault`  out  1: misalignment flag, pulses with `Ready`. Present only with the macro under Configuration.

## Operation
- FSM states: `IDLE`, `BUSY`, `DONE`.
- **IDLE**: on `Req`=1, latch `Address`, `Wr` and `DataIn`, and load the wait counter with `WAIT_STATES`. Go to `BUSY`, or directly to `DONE` when `WAIT_STATES`=0.
- **BUSY**: decrement the counter each cycle. Go to `DONE` when the counter reaches 1, or immediately if it was loaded with 1.
- **Entering DONE** (one edge does all of the following):
  - Write: update the array from the latched data.
  - Read: load `DataOut` from the array.
  - Drive `Ready`=1 for exactly one cycle.
- **DONE**: a `Req` sampled here is accepted as a new access (back-to-back), with the same transitions as `IDLE`. With no `Req`, return to `IDLE`.
- `Req` in `BUSY` is ignored. It is neither queued nor an error.
- **Word index**: `Address[log2(DEPTH_WORDS)+1:2]`. Higher bits are ignored, so accesses wrap modulo `DEPTH_WORDS`×4 bytes.
- **Byte order is big-endian**: byte `4k` holds `DataOut[31:24]` and byte `4k+3` holds `DataOut[7:0]`.
- **Read vs write data**: a write never changes `DataOut`. `DataOut` holds the last read value until the next read completes.
- **Reset**:
  - State returns to `IDLE`; `Ready`=0, `DataOut`=0, `Fault`=0, counter cleared.
  - Array contents are not cleared.
  - Reset asserted mid-access aborts it. A pending write is discarded, and no `Ready` is produced for it.
- **Simultaneous reset and `Req`**: reset wins and the request is dropped.

## Timing
- Latency: `Ready` is high in cycle N+`WAIT_STATES`+1 when `Req` is sampled at edge N.
- Read data is valid in the same cycle as `Ready`.
- Throughput: one access per `WAIT_STATES`+1 cycles when `Req` is held high continuously.
- A read issued back-to-back after a write to the same word returns the new data. The write commits before the following access is accepted.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- **`MEM_ALIGN_CHECK_EN` defined**:
  - A request with `Address[1:0]`≠0 completes with normal latency, with `Fault`=1 and `Ready`=1 in the same cycle.
  - The write is suppressed and `DataOut` is forced to 0.
  - This feeds the control FSM's exception path.
- **`MEM_ALIGN_CHECK_EN` undefined**:
  - The `Fault` port is absent.
  - `Address[1:0]` is ignored and every access is word-aligned.

## Structure
- **Shared package `mem_resp_pkg`**:
  - state enum (`IDLE`/`BUSY`/`DONE`);
  - `WAIT_W`=4 counter width;
  - byte-lane index constants (MSB lane = 0).
- **Sub-module `mem_byte_lanes`**: four 8-bit synchronous RAM lanes sharing one word index and one write enable, with big-endian lane mapping. The FSM lives in the top.

## Test plan
- **Reset mid-access**: reset while `BUSY` with a write of 0xDEADBEEF to 0x10 → no `Ready`; a following read of 0x10 returns the prior contents.
- **Write then read, `WAIT_STATES`=1**:
  - Write 0x12345678 to 0x08 → `Ready` exactly 2 cycles after `Req`.
  - Then read 0x08 → `DataOut`=0x12345678 with `Ready`.
- **Byte order**: write 0xAABBCCDD to 0x04 → lane 0 holds 0xAA and lane 3 holds 0xDD.
- **Wrap, `DEPTH_WORDS`=64**: write 0x11111111 to 0x100 → read 0x000 returns 0x11111111.
- **Back-to-back**: `Req` held high for 3 reads of 0x0, 0x4 and 0x8 → `Ready` pulses at cycles 2, 4 and 6. A `Req` asserted during `BUSY` produces no extra `Ready`.
- **Misaligned, `MEM_ALIGN_CHECK_EN`**: write to 0x0A → `Fault`=`Ready`=1 and the memory is unchanged. Without the macro, the same write lands at word 0x08.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared definitions for the CPU memory responder: FSM state encoding,
// wait-counter width and big-endian byte-lane numbering (lane 0 = MSB).
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WAIT_W    = 4;
  localparam int NUM_LANES = 4;

  // Lane numbers: lane 0 holds the most significant byte (lowest address).
  localparam int LANE_B0 = 0;
  localparam int LANE_B1 = 1;
  localparam int LANE_B2 = 2;
  localparam int LANE_B3 = 3;

  // Bit position of a lane's least significant bit within a 32-bit word.
  function automatic int lane_lsb(input int lane);
    return 8 * (NUM_LANES - 1 - lane);
  endfunction

endpackage

// File: rtl/mem_byte_lanes.sv
// Four 8-bit RAM lanes sharing one word index and one write enable.
// Big-endian mapping: lane 0 <-> data[31:24], lane 3 <-> data[7:0].
// Writes are synchronous; the read word is presented combinationally and
// registered by the parent.
module mem_byte_lanes
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 64
) (
  input  logic                           clock,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [7:0] lane_mem [NUM_LANES][DEPTH_WORDS];

  // All four lanes commit together on one edge.
  always_ff @(posedge clock) begin
    if (we) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        lane_mem[l][idx] <= wdata[lane_lsb(l) +: 8];
      end
    end
  end

  // Reassemble the addressed word from its lanes.
  always_comb begin
    rdata = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      rdata[lane_lsb(l) +: 8] = lane_mem[l][idx];
    end
  end

endmodule

// File: rtl/cpu_mem_responder.sv
// Responder side of the CPU memory port. Accepts word read/write requests,
// completes them after WAIT_STATES extra cycles with a one-cycle Ready pulse.
// Optional alignment check: define MEM_ALIGN_CHECK_EN to add the Fault output
// and reject accesses with Address[1:0] != 0.
module cpu_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        Ready
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        Fault
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  state_t            state;
  logic [WAIT_W-1:0] cnt;

  logic          wr_p0;
  logic          mis_p0;
  logic [AW-1:0] idx_p0;
  logic [31:0]   data_p0;

  logic          mis_in;
  logic          unused_addr;
  logic          accept;
  logic          fire_now;
  logic          fire;
  logic          acc_wr;
  logic          acc_mis;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_data;
  logic [31:0]   rdata;
  logic          mem_we;

`ifdef MEM_ALIGN_CHECK_EN
  assign mis_in      = |Address[1:0];
  assign unused_addr = ^Address[31:AW+2];
`else
  assign mis_in      = 1'b0;
  assign unused_addr = ^{Address[31:AW+2], Address[1:0]};
`endif

  // Decide whether an access completes on this edge and which operands it uses:
  // the live inputs for a zero-wait acceptance, otherwise the latched request.
  always_comb begin
    accept   = Req && (state != BUSY);
    fire_now = accept && (WAIT_STATES == 0);
    fire     = fire_now || ((state == BUSY) && (cnt <= WAIT_ONE));
    acc_wr   = fire_now ? Wr               : wr_p0;
    acc_mis  = fire_now ? mis_in           : mis_p0;
    acc_idx  = fire_now ? Address[AW+1:2]  : idx_p0;
    acc_data = fire_now ? DataIn           : data_p0;
    mem_we   = fire && acc_wr && !acc_mis && !reset;
  end

  // ---- stage p0: request operands captured at acceptance ----
  // Operand latch; holds data only, so it is not reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      wr_p0   <= Wr;
      mis_p0  <= mis_in;
      idx_p0  <= Address[AW+1:2];
      data_p0 <= DataIn;
    end
  end

  // ---- stage p1: array access and registered completion ----
  mem_byte_lanes #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_lanes (
    .clock (clock),
    .we    (mem_we),
    .idx   (acc_idx),
    .wdata (acc_data),
    .rdata (rdata)
  );

  // Control FSM: acceptance, wait countdown, completion pulse and read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      Ready   <= 1'b0;
      DataOut <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      Fault   <= 1'b0;
`endif
    end else begin
      Ready <= fire;
`ifdef MEM_ALIGN_CHECK_EN
      Fault <= fire && acc_mis;
`endif
      if (fire && acc_mis) begin
        DataOut <= '0;
      end else if (fire && !acc_wr) begin
        DataOut <= rdata;
      end
      case (state)
        IDLE, DONE: begin
          if (Req) begin
            cnt   <= WAIT_INIT;
            state <= (WAIT_STATES == 0) ? DONE : BUSY;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          cnt <= cnt - WAIT_ONE;
          if (cnt <= WAIT_ONE) begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: a driver issues directed and random
// requests; a reference model queues each accepted request with the cycle its
// completion is due; a monitor pops on Ready and checks timing, data and Fault.
module tb_cpu_mem_responder;

  localparam int DEPTH = 64;
  localparam int WS    = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        Req;
  logic        Wr;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        Ready;
`ifdef MEM_ALIGN_CHECK_EN
  logic        Fault;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int next_free = 0;

  typedef struct {
    bit          wr;
    int unsigned word;
    logic [31:0] data;
    bit          mis;
    int          due;
  } txn_t;

  txn_t        sbq[$];
  logic [7:0]  ref_mem [DEPTH*4];
  logic [31:0] last_rd = 32'h0;

  cpu_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_STATES (WS)
  ) u_dut (
    .clock   (clock),
    .reset   (reset),
    .Req     (Req),
    .Wr      (Wr),
    .Address (Address),
    .DataIn  (DataIn),
    .DataOut (DataOut),
    .Ready   (Ready)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .Fault   (Fault)
`endif
  );

  always #5 clock = ~clock;

  // Reference model: the port is free again one cycle after the previous
  // completion; an accepted request is due WS cycles after its edge.
  always @(posedge clock) begin
    txn_t t;
    cyc = cyc + 1;
    if (reset) begin
      sbq.delete();
      next_free = cyc + 1;
      last_rd = 32'h0;
    end else if (Req && cyc >= next_free) begin
      t.wr   = Wr;
      t.word = (Address >> 2) % DEPTH;
      t.data = DataIn;
`ifdef MEM_ALIGN_CHECK_EN
      t.mis  = (Address[1:0] != 2'b00);
`else
      t.mis  = 1'b0;
`endif
      t.due  = cyc + WS;
      sbq.push_back(t);
      next_free = cyc + WS + 1;
    end
  end

  // Monitor: effects are applied to the model only when the access completes.
  always @(negedge clock) begin
    txn_t t;
    if (Ready) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ready cyc=%0d DataOut=%h", cyc, DataOut);
      end else begin
        t = sbq.pop_front();
        checks++;
        if (cyc != t.due) begin
          errors++;
          $display("FAIL ready_latency got cyc=%0d expected cyc=%0d", cyc, t.due);
        end
        if (t.mis) begin
          last_rd = 32'h0;
        end else if (t.wr) begin
          ref_mem[t.word*4+0] = t.data[31:24];
          ref_mem[t.word*4+1] = t.data[23:16];
          ref_mem[t.word*4+2] = t.data[15:8];
          ref_mem[t.word*4+3] = t.data[7:0];
        end else begin
          last_rd = {ref_mem[t.word*4+0], ref_mem[t.word*4+1],
                     ref_mem[t.word*4+2], ref_mem[t.word*4+3]};
        end
        checks++;
        if (DataOut !== last_rd) begin
          errors++;
          $display("FAIL dataout word=%0d wr=%0b got=%h expected=%h", t.word, t.wr, DataOut, last_rd);
        end
`ifdef MEM_ALIGN_CHECK_EN
        checks++;
        if (Fault !== t.mis) begin
          errors++;
          $display("FAIL fault got=%0b expected=%0b", Fault, t.mis);
        end
`endif
      end
    end else if (sbq.size() != 0 && cyc > sbq[0].due) begin
      checks++; errors++;
      $display("FAIL missing_ready due cyc=%0d now cyc=%0d", sbq[0].due, cyc);
      void'(sbq.pop_front());
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clock);
    @(negedge clock);
  endtask

  // Single request pulse, then wait for its completion.
  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] data);
    Req = 1'b1; Wr = wr; Address = addr; DataIn = data;
    @(negedge clock);
    Req = 1'b0;
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; Req = 1'b0; Wr = 1'b0; Address = '0; DataIn = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("reset_ready", {31'h0, Ready}, 32'h0);
    chk("reset_dataout", DataOut, 32'h0);

    // Give every word a known value.
    for (int w = 0; w < DEPTH; w++) access(1'b1, w * 4, $urandom());

    // Write then read back.
    access(1'b1, 32'h08, 32'h12345678);
    access(1'b0, 32'h08, 32'h0);
    chk("readback_0x08", DataOut, 32'h12345678);

    // Byte order inside the lanes.
    access(1'b1, 32'h04, 32'hAABBCCDD);
    chk("lane0_msb", {24'h0, u_dut.u_lanes.lane_mem[0][1]}, 32'hAA);
    chk("lane3_lsb", {24'h0, u_dut.u_lanes.lane_mem[3][1]}, 32'hDD);

    // Address wrap modulo the array size.
    access(1'b1, 32'h100, 32'h11111111);
    access(1'b0, 32'h000, 32'h0);
    chk("wrap_read", DataOut, 32'h11111111);

    // Reset while a write is outstanding: no Ready, prior contents kept.
    access(1'b0, 32'h10, 32'h0);
    Req = 1'b1; Wr = 1'b1; Address = 32'h10; DataIn = 32'hDEADBEEF;
    @(negedge clock);
    Req = 1'b0; reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_dataout", DataOut, 32'h0);
    access(1'b0, 32'h10, 32'h0);

    // Back-to-back reads with Req held; junk operands during the wait.
    Req = 1'b1; Wr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      Address = k * 4;
      @(negedge clock);
      for (int j = 0; j < WS; j++) begin
        Wr = 1'b1; Address = $urandom(); DataIn = $urandom();
        @(negedge clock);
        Wr = 1'b0;
      end
    end
    Req = 1'b0;
    wait_idle();

    // Misaligned write (faults with the check, lands at word 2 without it).
    access(1'b1, 32'h0A, 32'h5555AAAA);
    access(1'b0, 32'h08, 32'h0);

    // Randomised traffic with occasional resets and held requests.
    for (int n = 0; n < 150; n++) begin
      int mode;
      mode = $urandom_range(0, 9);
      if (mode == 8) begin
        Req = 1'b1; Wr = $urandom_range(0, 1); Address = $urandom(); DataIn = $urandom();
        @(negedge clock);
        Req = 1'b0; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
      end else if (mode == 9) begin
        Req = 1'b1;
        for (int j = 0; j < $urandom_range(2, 8); j++) begin
          Wr = $urandom_range(0, 1); Address = $urandom_range(0, 4 * DEPTH * 2 - 1);
          DataIn = $urandom();
          @(negedge clock);
        end
        Req = 1'b0;
        wait_idle();
      end else begin
        access($urandom_range(0, 1), $urandom(), $urandom());
        repeat ($urandom_range(0, 2)) @(negedge clock);
      end
    end

    wait_idle();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_pending got=%0d expected=0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
